// File: rtl/data_memory_bytelane_if.sv
// Request/response bundle for the byte-lane data memory.
// Ports: req_* (valid/ready request with store data), rsp_* (one-cycle response pulse).
// master = requester (execute stage), slave = memory.
interface data_memory_bytelane_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressed single-port data memory with LB/LH/LW/LBU/LHU/SB/SH/SW and error flagging.
// Latency: response exactly one cycle after acceptance; full throughput back-to-back.
// Backpressure: req_ready low only while the post-reset clear sequence runs (busy=1).
// Ports: clk, rst (sync, active-high), bus (slave side of data_memory_bytelane_if), busy.
module data_memory_bytelane #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_bytelane_if.slave   bus,
  output logic                    busy
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;

  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t          state, state_nxt;
  logic [IW-1:0]   cnt;
  logic            clear_we;
  logic [31:0]     mem [WORDS];

  logic [IW-1:0]   widx;
  logic [1:0]      lane;
  logic            accept;
  logic            err;
  logic [3:0]      be;
  logic [31:0]     wdat;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [15:0]     rd_half;
  logic [31:0]     ld_data;

  assign widx = bus.req_addr[ADDR_WIDTH-1:2];
  assign lane = bus.req_addr[1:0];

  // FSM: next state and per-state outputs
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    clear_we      = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      RUN: begin
        bus.req_ready = 1'b1;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clear_we) cnt <= cnt + 1'b1;
    end
  end

  // A request arriving in the reset cycle is dropped, never half-executed.
  assign accept = bus.req_valid && bus.req_ready && !rst;

  always_comb begin
    err = 1'b0;
    case (bus.req_size)
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    be   = 4'b0000;
    wdat = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wdat = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        be   = 4'b1111;
        wdat = bus.req_wdata;
      end
      default: begin
        be   = 4'b0000;
        wdat = bus.req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) begin
        mem[cnt] <= '0;
      end else if (accept && bus.req_we && !err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

  // Load field extraction and extension
  assign rd_word  = mem[widx];
  assign rd_shift = rd_word >> {lane, 3'b000};
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    case (bus.req_size)
      2'b00: ld_data = bus.req_unsigned ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: ld_data = bus.req_unsigned ? {16'h0, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  // Response register: rdata holds its last value between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_err   <= accept && err;
      if (accept) bus.rsp_rdata <= (err || bus.req_we) ? 32'h0 : ld_data;
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  data_memory_bytelane_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_bytelane #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic [7:0]  addr;
    logic [15:0] id;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mm [64];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_rsp_cyc = -10;
  int         prev_rsp_cyc = -10;
  int         req_id = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference model: flat byte array, little-endian, addresses wrap at 64
  function automatic bit model_err(input logic [1:0] size, input int a);
    return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [1:0] size, input bit uns);
    logic [31:0] v;
    v = 32'(mm[a]);
    if (size == 2'd0) begin
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v + 32'(mm[(a+1)%64]) * 256;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = v + 32'(mm[(a+1)%64]) * 256 + 32'(mm[(a+2)%64]) * 65536 + 32'(mm[(a+3)%64]) * 16777216;
    end
    return v;
  endfunction

  task automatic model_store(input int a, input logic [1:0] size, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    w = wd;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      mm[(a+i)%64] = w[7:0];
      w = w >> 8;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
  endtask

  // Drive one request; the expected response is queued at the accepting edge.
  task automatic issue(input bit we, input int a, input logic [1:0] size, input bit uns,
                       input logic [31:0] wd, input bit use_exp, input logic [31:0] ed, input bit ee);
    int   n;
    exp_t x;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = AW'(a);
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h got ready=0 want ready=1", a);
    end else begin
      @(posedge clk);
      x.addr = 8'(a);
      x.id   = 16'(req_id);
      req_id++;
      if (use_exp) begin
        x.d = ed;
        x.e = ee;
      end else begin
        x.e = model_err(size, a);
        x.d = (x.e || we) ? 32'h0 : model_load(a, size, uns);
      end
      if (we && !model_err(size, a)) model_store(a, size, wd);
      exp_q.push_back(x);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (n < 1000) begin
      @(negedge clk);
      if (!busy) break;
      if (bus.req_ready) rdy_seen = 1'b1;
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'd16);
    chk({name, "_ready_in_clear"}, 32'(rdy_seen), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp got rdata=%h err=%b want no response", bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_rdata !== e.d || bus.rsp_err !== e.e) begin
            errors++;
            $display("FAIL rsp id=%0d addr=%h got rdata=%h err=%b want rdata=%h err=%b",
                     e.id, e.addr, bus.rsp_rdata, bus.rsp_err, e.d, e.e);
          end
        end
        prev_rsp_cyc = last_rsp_cyc;
        last_rsp_cyc = cyc;
      end else begin
        checks++;
        if (bus.rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_err got=%b want=0", bus.rsp_err);
        end
      end
    end
  end

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    model_clear();

    // Reset state, then full clear sequence
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    count_busy("init");
    issue(0, 'h3C, 2'd2, 0, 0, 1, 32'h0, 0);

    // Byte merge
    issue(1, 'h10, 2'd2, 0, 32'h11223344, 1, 32'h0, 0);
    issue(1, 'h11, 2'd0, 0, 32'h000000AB, 1, 32'h0, 0);
    issue(1, 'h12, 2'd1, 0, 32'h0000BEEF, 1, 32'h0, 0);
    issue(0, 'h10, 2'd2, 0, 0, 1, 32'hBEEFAB44, 0);

    // Sign / zero extension
    issue(1, 'h20, 2'd2, 0, 32'h80F17FFF, 1, 32'h0, 0);
    issue(0, 'h23, 2'd0, 0, 0, 1, 32'hFFFFFF80, 0);
    issue(0, 'h23, 2'd0, 1, 0, 1, 32'h00000080, 0);
    issue(0, 'h20, 2'd1, 0, 0, 1, 32'h00007FFF, 0);
    issue(0, 'h22, 2'd1, 0, 0, 1, 32'hFFFF80F1, 0);
    issue(0, 'h22, 2'd1, 1, 0, 1, 32'h000080F1, 0);
    issue(0, 'h20, 2'd2, 1, 0, 1, 32'h80F17FFF, 0);

    // Misaligned / illegal accesses leave memory untouched
    issue(1, 'h30, 2'd2, 0, 32'h5A5AA5A5, 1, 32'h0, 0);
    issue(0, 'h22, 2'd2, 0, 0, 1, 32'h0, 1);
    issue(0, 'h21, 2'd1, 0, 0, 1, 32'h0, 1);
    issue(1, 'h31, 2'd2, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    issue(1, 'h30, 2'd3, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    issue(0, 'h30, 2'd3, 0, 0, 1, 32'h0, 1);
    issue(0, 'h30, 2'd2, 0, 0, 1, 32'h5A5AA5A5, 0);

    // Back-to-back store then load of the same word
    repeat (2) @(posedge clk);
    #1;
    issue(1, 'h08, 2'd2, 0, 32'hCAFEF00D, 1, 32'h0, 0);
    issue(0, 'h08, 2'd2, 0, 0, 1, 32'hCAFEF00D, 0);
    @(negedge clk);
    #1;
    chk("b2b_rsp_spacing", 32'(last_rsp_cyc - prev_rsp_cyc), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      int a;
      int s;
      logic [1:0] size;
      a = $urandom_range(0, 63);
      s = $urandom_range(0, 9);
      size = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 2) != 0) a = (size == 2'd1) ? (a & ~1) : (size == 2'd2) ? (a & ~3) : a;
      issue($urandom_range(0, 1) == 1, a, size, $urandom_range(0, 1) == 1, $urandom, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset while a load response is in flight and a new load is pending
    issue(1, 'h00, 2'd2, 0, 32'h12345678, 1, 32'h0, 0);
    issue(1, 'h3C, 2'd2, 0, 32'h9ABCDEF0, 1, 32'h0, 0);
    issue(0, 'h3C, 2'd2, 0, 0, 1, 32'h9ABCDEF0, 0);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_addr     = AW'('h10);
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_busy("restart");
    issue(0, 'h10, 2'd2, 0, 0, 1, 32'h0, 0);
    issue(0, 'h00, 2'd2, 0, 0, 1, 32'h0, 0);
    issue(0, 'h3C, 2'd2, 0, 0, 1, 32'h0, 0);

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Parametrised successor to the word-only data memory for the RV32 datapath.
- Single-port, byte-addressed memory with a valid/ready request handshake and byte/half/word accesses.
- Loads are sign- or zero-extended; misaligned or illegal accesses are flagged.
- Registered read with 1-cycle response, plus optional clear-on-reset sequencing. Sits between the execute stage and writeback (LB/LH/LW/LBU/LHU/SB/SH/SW).

Parameters:
- ADDR_WIDTH, 12, byte-address width; depth = 2^(ADDR_WIDTH-2) 32-bit words; legal values 3..20.
- CLEAR_ON_RESET, 1, when 1 every word is zeroed after reset before requests are accepted; when 0 contents are undefined and the block is ready immediately.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for word loads and stores
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse, response for the request accepted the previous cycle
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access, valid with rsp_valid
- busy  out  1  clear sequence in progress

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0.
  - Next state is CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Reset overrides any in-flight request; a response pending at the reset edge is dropped.
- FSM states: CLEAR, RUN.
  - CLEAR:
    - busy=1, req_ready=0.
    - Writes 0 to word[cnt] each cycle; cnt increments.
    - On cnt = 2^(ADDR_WIDTH-2)-1 the last word is written and next state is RUN.
    - Duration is exactly 2^(ADDR_WIDTH-2) cycles after reset deasserts.
    - Reset asserted mid-clear restarts from word 0.
  - RUN:
    - busy=0, req_ready=1 every cycle.
    - No self-exit; only rst leaves RUN.
- Acceptance: a request is accepted when req_valid && req_ready at posedge. req_valid during CLEAR is ignored, not queued.
- Addressing: word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
- Error conditions:
  - size=11.
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]≠0.
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
- Store, written at the accepting edge:
  - byte: wdata[7:0] into lane addr[1:0].
  - half: wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Unaddressed lanes are unchanged. Store response: rsp_valid=1, rsp_rdata=0, rsp_err=0.
- Load: word read at the accepting edge and the addressed field extracted.
  - byte/half: sign-extended from bit 7/15 unless req_unsigned=1, then zero-extended.
  - Result registered and presented the next cycle with rsp_valid=1.
- Latency and throughput: every accepted request produces exactly one response on the following cycle. Back-to-back requests give back-to-back responses at full throughput.
- Ordering: a store accepted in cycle N is visible to a load accepted in cycle N+1 (array updated at N's edge).
- Little-endian lane order: lane 0 = bits [7:0].
- Idle outputs: when rsp_valid=0, rsp_err=0 and rsp_rdata holds its last value.
- Address range: out-of-range addresses cannot occur (the address is exactly ADDR_WIDTH bits); the maximum address wraps naturally with no special case.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=6, rst 1 cycle -> busy=1 and req_ready=0 for exactly 16 cycles; then LW 0x3C -> rsp_rdata=0x00000000, rsp_err=0.
- Byte merge: SW 0x10 ← 0x11223344; SB 0x11 ← 0xAB; SH 0x12 ← 0xBEEF; LW 0x10 -> 0xBEEFAB44.
- Extension: memory word 0x20 = 0x80F17FFF.
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
  - LH 0x20 -> 0x00007FFF; LH 0x22 -> 0xFFFF80F1; LHU 0x22 -> 0x000080F1.
- Misalign: LW 0x22, LH 0x21, SW 0x31 ← 0xFFFFFFFF, size=11 at 0x30 -> each rsp_err=1, rsp_rdata=0; then LW 0x30 returns the prior contents unchanged.
- Back-to-back: SW 0x08 ← 0xCAFEF00D in cycle N, LW 0x08 in N+1 -> rsp_valid high in N+1 and N+2, second response 0xCAFEF00D.
- Reset mid-operation: rst asserted the cycle after a load is accepted -> no rsp_valid pulse, outputs 0, busy=1 for a full clear sequence restarted from word 0; a request held valid during CLEAR is not accepted until busy=0.
